// File: rtl/pipe_pkg.sv
// Shared widths, bubble encodings and counter defaults for the four
// inter-stage pipeline registers of the processor datapath.
package pipe_pkg;

    localparam int CNT_W_DEFAULT = 16;

    localparam int IFID_CTRL_W  = 16;
    localparam int IFID_DATA_W  = 64;
    localparam int IDEX_CTRL_W  = 16;
    localparam int IDEX_DATA_W  = 128;
    localparam int EXMEM_CTRL_W = 8;
    localparam int EXMEM_DATA_W = 112;
    localparam int MEMWB_CTRL_W = 4;
    localparam int MEMWB_DATA_W = 72;

    // Every write/enable bit is active-high, so all-zero is a safe bubble.
    localparam logic [IFID_CTRL_W-1:0]  IFID_BUBBLE  = '0;
    localparam logic [IDEX_CTRL_W-1:0]  IDEX_BUBBLE  = '0;
    localparam logic [EXMEM_CTRL_W-1:0] EXMEM_BUBBLE = '0;
    localparam logic [MEMWB_CTRL_W-1:0] MEMWB_BUBBLE = '0;

endpackage

// File: rtl/sat_counter.sv
// Unsigned saturating event counter with synchronous clear that
// overrides a same-cycle increment.
module sat_counter
    import pipe_pkg::*;
#(
    parameter int W = CNT_W_DEFAULT
) (
    input  logic         Clock,
    input  logic         Reset_n,
    input  logic         Clear,
    input  logic         Inc,
    output logic [W-1:0] Count
);

    localparam logic [W-1:0] ONE = W'(1);
    localparam logic [W-1:0] MAX = '1;

    logic [W-1:0] count_q;
    logic [W-1:0] count_d;

    always_comb begin
        count_d = count_q;
        if (Clear) begin
            count_d = '0;
        end else if (Inc && (count_q != MAX)) begin
            count_d = count_q + ONE;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            count_q <= '0;
        end else begin
            count_q <= count_d;
        end
    end

    assign Count = count_q;

endmodule

// File: rtl/pipe_stage_reg.sv
// Inter-stage pipeline register with stall hold, flush bubble insertion,
// invalid-input control gating and saturating stall/flush event counters.
module pipe_stage_reg
    import pipe_pkg::*;
#(
    parameter int                DATA_W      = 128,
    parameter int                CTRL_W      = 16,
    parameter logic [CTRL_W-1:0] BUBBLE_CTRL = {CTRL_W{1'b0}},
    parameter int                CNT_W       = CNT_W_DEFAULT
) (
    input  logic              Clock,
    input  logic              Reset_n,
    input  logic              Stall,
    input  logic              Flush,
    input  logic              ClearCounters,
    input  logic              ValidIn,
    input  logic [CTRL_W-1:0] CtrlIn,
    input  logic [DATA_W-1:0] DataIn,
    output logic              ValidOut,
    output logic [CTRL_W-1:0] CtrlOut,
    output logic [DATA_W-1:0] DataOut,
    output logic [CNT_W-1:0]  StallCount,
    output logic [CNT_W-1:0]  FlushCount
);

    logic              valid_q, valid_d;
    logic [CTRL_W-1:0] ctrl_q,  ctrl_d;
    logic [DATA_W-1:0] data_q,  data_d;
    logic              stall_inc;
    logic              flush_inc;

    // Flush beats Stall beats Load; data is left alone on flush to save toggles.
    always_comb begin
        valid_d = valid_q;
        ctrl_d  = ctrl_q;
        data_d  = data_q;
        if (Flush) begin
            valid_d = 1'b0;
            ctrl_d  = BUBBLE_CTRL;
        end else if (!Stall) begin
            valid_d = ValidIn;
            data_d  = DataIn;
            ctrl_d  = ValidIn ? CtrlIn : BUBBLE_CTRL;
        end
    end

    always_ff @(posedge Clock or negedge Reset_n) begin
        if (!Reset_n) begin
            valid_q <= 1'b0;
            ctrl_q  <= BUBBLE_CTRL;
            data_q  <= '0;
        end else begin
            valid_q <= valid_d;
            ctrl_q  <= ctrl_d;
            data_q  <= data_d;
        end
    end

    assign stall_inc = Stall && !Flush && valid_q;
    assign flush_inc = Flush && (valid_q || ValidIn);

    sat_counter #(.W(CNT_W)) u_stall_cnt (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Clear   (ClearCounters),
        .Inc     (stall_inc),
        .Count   (StallCount)
    );

    sat_counter #(.W(CNT_W)) u_flush_cnt (
        .Clock   (Clock),
        .Reset_n (Reset_n),
        .Clear   (ClearCounters),
        .Inc     (flush_inc),
        .Count   (FlushCount)
    );

    assign ValidOut = valid_q;
    assign CtrlOut  = ctrl_q;
    assign DataOut  = data_q;

endmodule

// File: doc/pipe_stage_reg.md
Name: pipe_stage_reg

Overview:
Parametrised inter-stage pipeline register for the processor datapath, used for IF/ID, ID/EX, EX/MEM and MEM/WB.
- Carries a control bundle, a data bundle and a valid bit.
- Adds stall (hold), flush (bubble insertion) and invalid-input gating, which the fixed-field stage registers lack.
- Keeps saturating stall and flush event counters for performance debug.
- One-cycle latency; each stage instantiates it with its own widths and bubble encoding.

Parameters:
DATA_W, 128, width of the data bundle (PC+4, register operands, immediate, register indices, etc.)
CTRL_W, 16, width of the control bundle (write-back, memory and execute control signals)
BUBBLE_CTRL, {CTRL_W{1'b0}}, control value loaded on reset, flush or invalid input; must deassert every write/enable
CNT_W, 16, width of each event counter

Ports:
Clock  input  1  rising-edge clock
Reset_n  input  1  asynchronous, active-low reset
Stall  input  1  hold all stage contents this cycle
Flush  input  1  replace stage contents with a bubble this cycle
ClearCounters  input  1  synchronous clear of both event counters
ValidIn  input  1  upstream stage holds a real instruction
CtrlIn  input  CTRL_W  upstream control bundle
DataIn  input  DATA_W  upstream data bundle
ValidOut  output  1  registered valid
CtrlOut  output  CTRL_W  registered control bundle
DataOut  output  DATA_W  registered data bundle
StallCount  output  CNT_W  cycles a valid instruction was held by Stall
FlushCount  output  CNT_W  flush events that killed a valid or incoming instruction

Behaviour:
- Reset (Reset_n=0, asynchronous, any time including mid-stall or mid-flush):
  - ValidOut=0, CtrlOut=BUBBLE_CTRL, DataOut=0, StallCount=0, FlushCount=0.
  - Takes effect immediately, not on the next edge; normal operation resumes on the first rising edge after Reset_n=1.
- Latency: 1 clock from inputs to outputs when neither Stall nor Flush is asserted.
- Priority at each rising edge: Flush > Stall > Load.
- Flush=1 (Stall ignored):
  - ValidOut<=0, CtrlOut<=BUBBLE_CTRL; DataOut holds its value (don't-care, held to save toggles).
  - FlushCount increments if ValidOut==1 or ValidIn==1.
- Stall=1, Flush=0:
  - ValidOut, CtrlOut and DataOut all hold.
  - StallCount increments if ValidOut==1; stalling a bubble is not counted.
- Load (Stall=0, Flush=0):
  - ValidOut<=ValidIn and DataOut<=DataIn.
  - CtrlOut<=CtrlIn if ValidIn=1, else BUBBLE_CTRL. An invalid input can never reach downstream with live enables.
- Counters:
  - Unsigned; saturate at 2^CNT_W-1 with no wrap.
  - ClearCounters=1 loads 0 on the next edge and wins over a same-cycle increment.
  - Counters are independent of Stall/Flush holding of the data path.
- Simultaneous Stall and Flush: treated as Flush. Only FlushCount may increment; StallCount does not.
- No combinational path from any input to any output; all outputs come directly from flops.

Decomposition:
- Shared package pipe_pkg:
  - per-stage CTRL_W and DATA_W localparams (IFID, IDEX, EXMEM, MEMWB)
  - per-stage BUBBLE_CTRL constants
  - default CNT_W
- Sub-module sat_counter (params W; ports Clock, Reset_n, Clear, Inc, Count), instantiated twice for StallCount and FlushCount.
- Payload register stays inline in pipe_stage_reg.

Test Plan:
- Reset then load: hold Reset_n=0 for 3 cycles, release, apply ValidIn=1, CtrlIn=16'h00A5, DataIn=128'h1234 -> one edge later ValidOut=1, CtrlOut=16'h00A5, DataOut=128'h1234; during reset all outputs and counters read 0 immediately.
- Stall hold: with ValidOut=1, assert Stall for 4 cycles while DataIn changes every cycle -> DataOut and CtrlOut unchanged, StallCount=4; release -> the current DataIn appears one edge later.
- Flush, and flush+stall together: assert Flush with ValidIn=1 -> ValidOut=0, CtrlOut=BUBBLE_CTRL, FlushCount=1; assert Stall and Flush together -> bubble inserted, FlushCount=2, StallCount unchanged.
- Invalid input gating: ValidIn=0, CtrlIn=16'hFFFF -> CtrlOut=BUBBLE_CTRL, ValidOut=0, DataOut=DataIn.
- Counter saturation and clear: CNT_W=4, stall a valid instruction for 20 cycles -> StallCount sticks at 15; assert ClearCounters on the same cycle as a stall -> StallCount=0.
- Asynchronous reset mid-stall: assert Reset_n=0 between clock edges during a stall -> outputs clear before the next edge; after release the stage loads fresh inputs.
